// File: rtl/rk_dma_pkg.sv
// Shared types, defaults and the round-robin pick helper for the RK8E/SD DMA arbiter.
package rk_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    OWN  = 2'b10,
    GAP  = 2'b11
  } arbSTATE_t;

  localparam int DEF_GAP     = 4;
  localparam int DEF_TIMEOUT = 1024;
  localparam int RR_MAXCH    = 8;

  // First set bit of req at or after ptr, wrapping modulo nch.
  // Result is {valid, index}; request vectors are zero-extended to 8 bits.
  function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         nch);
    logic       found;
    logic [2:0] idx;
    int         n;
    int         cand;
    found = 1'b0;
    idx   = 3'd0;
    n     = (nch < 1) ? 1 : nch;
    for (int k = 0; k < RR_MAXCH; k++) begin
      cand = (int'(ptr) + k) % n;
      if ((k < n) && !found && req[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rk_dma_rrpick.sv
// Combinational round-robin priority encoder: request vector + pointer -> winner index.
module rk_dma_rrpick
  import rk_dma_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  idx,
  output logic           valid
);

  logic [7:0] req_s;
  logic [3:0] res_s;

  // Widen the request vector to the helper's fixed width and pick the winner.
  always_comb begin
    req_s          = 8'h00;
    req_s[NCH-1:0] = req;
    res_s          = rr_pick(req_s, 3'(ptr), NCH);
    idx            = PW'(res_s[2:0]);
    valid          = res_s[3];
  end

endmodule

// File: rtl/rk_dma_arb.sv
// Merges NCH sd-style DMA masters onto the single PDP-8 DMA port with
// round-robin fairness, an upstream hold-off gap and a per-channel stall watchdog.
module rk_dma_arb
  import rk_dma_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = 15,
  parameter int DW      = 12,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int OW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [NCH-1:0]    chREQ,
  input  logic [NCH-1:0]    chRD,
  input  logic [NCH-1:0]    chWR,
  input  logic [NCH*AW-1:0] chADDR,
  input  logic [NCH*DW-1:0] chDOUT,
  output logic [NCH-1:0]    chGNT,
  output logic [DW-1:0]     chDIN,
  output logic              dmaREQ,
  input  logic              dmaGNT,
  output logic [AW-1:0]     dmaADDR,
  output logic [DW-1:0]     dmaDOUT,
  output logic              dmaRD,
  output logic              dmaWR,
  input  logic [DW-1:0]     dmaDIN,
  output logic [OW-1:0]     owner,
  output logic [NCH-1:0]    errFLAG,
  input  logic [NCH-1:0]    errCLR
);

  localparam int              WW       = $clog2(TIMEOUT);
  localparam logic [OW-1:0]   LAST_CH  = OW'(NCH - 1);
  localparam logic [WW-1:0]   WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP - 1);

  arbSTATE_t       state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [7:0]      gap_q, gap_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            dma_req_q, dma_req_d;
  logic [NCH-1:0]  ch_gnt_q, ch_gnt_d;
  logic [NCH-1:0]  err_flag_q, err_flag_d;

  logic [NCH-1:0]  elig_s;
  logic [NCH-1:0]  owner_oh_s;
  logic [NCH-1:0]  err_set_s;
  logic [OW-1:0]   pick_idx_s;
  logic            pick_vld_s;
  logic [OW-1:0]   rr_next_s;
  logic            own_req_s;
  logic            own_stb_s;
  logic            own_gnt_s;
  logic            wd_hit_s;

  // Channels with a sticky watchdog error sit out arbitration until cleared.
  rk_dma_rrpick #(
    .NCH (NCH),
    .PW  (OW)
  ) u_pick (
    .req   (elig_s),
    .ptr   (rr_q),
    .idx   (pick_idx_s),
    .valid (pick_vld_s)
  );

  // Views of the current owner channel shared by the FSM and the data muxes.
  always_comb begin
    elig_s    = chREQ & ~err_flag_q;
    own_req_s = chREQ[owner_q];
    own_stb_s = chRD[owner_q] | chWR[owner_q];
    own_gnt_s = ch_gnt_q[owner_q];
    for (int i = 0; i < NCH; i++) begin
      owner_oh_s[i] = (owner_q == OW'(i));
    end
    if (owner_q == LAST_CH) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = owner_q + OW'(1);
    end
  end

  // Next-state logic: arbitration, grant hand-off, watchdog and hold-off gap.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    gap_d     = gap_q;
    wd_d      = wd_q;
    dma_req_d = dma_req_q;
    ch_gnt_d  = ch_gnt_q;
    err_set_s = '0;
    wd_hit_s  = 1'b0;
    case (state_q)
      IDLE: begin
        ch_gnt_d  = '0;
        if (pick_vld_s) begin
          owner_d   = pick_idx_s;
          dma_req_d = 1'b1;
          state_d   = REQ;
        end else begin
          dma_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      REQ: begin
        ch_gnt_d = '0;
        if (!own_req_s) begin
          // Master gave up before the CPU answered: no grant, still honour the gap.
          dma_req_d = 1'b0;
          gap_d     = 8'd0;
          state_d   = rk_dma_pkg::GAP;
        end else if (dmaGNT) begin
          dma_req_d = 1'b1;
          ch_gnt_d  = owner_oh_s;
          wd_d      = '0;
          state_d   = OWN;
        end else begin
          dma_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      OWN: begin
        wd_hit_s = ~own_stb_s & (wd_q == WD_LAST);
        if (!own_req_s || wd_hit_s) begin
          if (wd_hit_s) begin
            err_set_s = owner_oh_s;
          end else begin
            err_set_s = '0;
          end
          ch_gnt_d  = '0;
          dma_req_d = 1'b0;
          rr_d      = rr_next_s;
          gap_d     = 8'd0;
          state_d   = rk_dma_pkg::GAP;
        end else if (!dmaGNT) begin
          // CPU took the bus back: keep the owner and ask again.
          ch_gnt_d  = '0;
          dma_req_d = 1'b1;
          state_d   = REQ;
        end else begin
          ch_gnt_d  = owner_oh_s;
          dma_req_d = 1'b1;
          if (own_stb_s) begin
            wd_d = '0;
          end else begin
            wd_d = wd_q + WW'(1);
          end
          state_d = OWN;
        end
      end
      rk_dma_pkg::GAP: begin
        ch_gnt_d  = '0;
        dma_req_d = 1'b0;
        // The last gap cycle doubles as the arbitration cycle so that the
        // upstream request stays low for exactly GAP cycles.
        if (gap_q >= GAP_LAST) begin
          if (pick_vld_s) begin
            owner_d   = pick_idx_s;
            dma_req_d = 1'b1;
            state_d   = REQ;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          gap_d   = gap_q + 8'd1;
          state_d = rk_dma_pkg::GAP;
        end
      end
      default: begin
        ch_gnt_d  = '0;
        dma_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    // A watchdog set beats a simultaneous software clear of the same bit.
    err_flag_d = (err_flag_q & ~errCLR) | err_set_s;
  end

  // Owner-channel data path; nothing reaches memory unless a grant is held.
  always_comb begin
    chDIN = dmaDIN;
    if (own_gnt_s) begin
      dmaADDR = chADDR[int'(owner_q)*AW +: AW];
      dmaDOUT = chDOUT[int'(owner_q)*DW +: DW];
      dmaRD   = chRD[owner_q];
      dmaWR   = chWR[owner_q];
    end else begin
      dmaADDR = '0;
      dmaDOUT = '0;
      dmaRD   = 1'b0;
      dmaWR   = 1'b0;
    end
  end

  // State and registered outputs; IOCLR resets everything but the error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      gap_q      <= 8'd0;
      wd_q       <= '0;
      dma_req_q  <= 1'b0;
      ch_gnt_q   <= '0;
      err_flag_q <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      gap_q      <= 8'd0;
      wd_q       <= '0;
      dma_req_q  <= 1'b0;
      ch_gnt_q   <= '0;
      err_flag_q <= err_flag_q & ~errCLR;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      dma_req_q  <= dma_req_d;
      ch_gnt_q   <= ch_gnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign chGNT   = ch_gnt_q;
  assign dmaREQ  = dma_req_q;
  assign owner   = owner_q;
  assign errFLAG = err_flag_q;

endmodule

// File: tb/tb_rk_dma_arb.sv
// Self-checking bench for rk_dma_arb: behavioural model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_rk_dma_arb;

  localparam int NCH     = 2;
  localparam int AW      = 15;
  localparam int DW      = 12;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 1024;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_ASK   = 3'd1;
  localparam logic [2:0] PH_HOLD  = 3'd2;
  localparam logic [2:0] PH_QUIET = 3'd3;

  logic              clk;
  logic              reset, clear;
  logic [NCH-1:0]    chREQ, chRD, chWR, chGNT, errFLAG, errCLR;
  logic [NCH*AW-1:0] chADDR;
  logic [NCH*DW-1:0] chDOUT;
  logic [DW-1:0]     chDIN, dmaDOUT, dmaDIN;
  logic              dmaREQ, dmaGNT, dmaRD, dmaWR;
  logic [AW-1:0]     dmaADDR;
  logic [0:0]        owner;

  int n_pass  = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  rk_dma_arb #(
    .NCH(NCH), .AW(AW), .DW(DW), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .chREQ(chREQ), .chRD(chRD), .chWR(chWR), .chADDR(chADDR), .chDOUT(chDOUT),
    .chGNT(chGNT), .chDIN(chDIN),
    .dmaREQ(dmaREQ), .dmaGNT(dmaGNT), .dmaADDR(dmaADDR), .dmaDOUT(dmaDOUT),
    .dmaRD(dmaRD), .dmaWR(dmaWR), .dmaDIN(dmaDIN),
    .owner(owner), .errFLAG(errFLAG), .errCLR(errCLR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0] phase;
    int         owner;
    int         rr;
    int         quiet;   // gap cycles still to run
    int         silent;  // consecutive held cycles without a strobe
    logic [1:0] gnt;
    logic       req;
    logic [1:0] err;
  } mdl_t;

  mdl_t mdl = '0;

  function automatic int first_req(input logic [1:0] r, input int ptr);
    for (int k = 0; k < NCH; k++) begin
      if (r[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic rst, input logic clr,
                                    input logic [1:0] req, input logic [1:0] rd,
                                    input logic [1:0] wr, input logic up_gnt,
                                    input logic [1:0] eclr);
    mdl_t n;
    int   w;
    logic hit;
    n = m;
    if (rst) begin
      n = '0;
      return n;
    end
    if (clr) begin
      n = '0;
      n.err = m.err & ~eclr;
      return n;
    end
    n.err = m.err & ~eclr;
    case (m.phase)
      PH_IDLE: begin
        w = first_req(req & ~m.err, m.rr);
        if (w >= 0) begin
          n.owner = w; n.phase = PH_ASK; n.req = 1'b1;
        end
      end
      PH_ASK: begin
        if (!req[m.owner]) begin
          n.req = 1'b0; n.phase = PH_QUIET; n.quiet = GAP;
        end else if (up_gnt) begin
          n.phase = PH_HOLD; n.gnt = 2'(1 << m.owner); n.silent = 0;
        end
      end
      PH_HOLD: begin
        n.silent = (rd[m.owner] | wr[m.owner]) ? 0 : m.silent + 1;
        hit = (n.silent >= TIMEOUT);
        if (!req[m.owner] || hit) begin
          if (hit) n.err[m.owner] = 1'b1;
          n.gnt = 2'b00; n.req = 1'b0; n.rr = (m.owner + 1) % NCH;
          n.quiet = GAP; n.phase = PH_QUIET;
        end else if (!up_gnt) begin
          n.gnt = 2'b00; n.phase = PH_ASK;
        end
      end
      default: begin
        n.quiet = m.quiet - 1;
        if (n.quiet == 0) begin
          w = first_req(req & ~m.err, m.rr);
          if (w >= 0) begin
            n.owner = w; n.phase = PH_ASK; n.req = 1'b1;
          end else begin
            n.phase = PH_IDLE;
          end
        end
      end
    endcase
    return n;
  endfunction

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge clk) mdl <= mdl_step(mdl, reset, clear, chREQ, chRD, chWR, dmaGNT, errCLR);

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_chGNT", 32'(chGNT), 32'(mdl.gnt));
      chk("m_dmaREQ", 32'(dmaREQ), 32'(mdl.req));
      chk("m_owner", 32'(owner), 32'(mdl.owner));
      chk("m_errFLAG", 32'(errFLAG), 32'(mdl.err));
      chk("m_dmaADDR", 32'(dmaADDR), (mdl.gnt != 2'b00) ? 32'(chADDR[mdl.owner*AW +: AW]) : 32'd0);
      chk("m_dmaDOUT", 32'(dmaDOUT), (mdl.gnt != 2'b00) ? 32'(chDOUT[mdl.owner*DW +: DW]) : 32'd0);
      chk("m_dmaRD", 32'(dmaRD), (mdl.gnt != 2'b00) ? 32'(chRD[mdl.owner]) : 32'd0);
      chk("m_dmaWR", 32'(dmaWR), (mdl.gnt != 2'b00) ? 32'(chWR[mdl.owner]) : 32'd0);
      chk("m_chDIN", 32'(chDIN), 32'(dmaDIN));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; clear = 1'b0; chREQ = 2'b00; chRD = 2'b00; chWR = 2'b00;
    chADDR = '0; chDOUT = '0; dmaGNT = 1'b0; dmaDIN = 12'o0000; errCLR = 2'b00;
    tick(2);
    chk_en = 1'b1;
    chk("rst_gnt", 32'(chGNT), 32'd0);
    chk("rst_req", 32'(dmaREQ), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_err", 32'(errFLAG), 32'd0);
    reset = 1'b0;
    tick(1);

    // Single master: request latency, grant latency, address mux, data paths.
    chADDR = {15'o00000, 15'o00200};
    chREQ = 2'b01;
    tick(1);
    chk("s1_req_lat", 32'(dmaREQ), 32'd1);
    chk("s1_no_gnt", 32'(chGNT), 32'd0);
    tick(2);
    dmaGNT = 1'b1;
    tick(1);
    chk("s1_gnt", 32'(chGNT), 32'd1);
    chk("s1_addr", 32'(dmaADDR), 32'o00200);
    chRD = 2'b01; dmaDIN = 12'o5252; #1;
    chk("s1_din", 32'(chDIN), 32'o5252);
    chk("s1_rd", 32'(dmaRD), 32'd1);
    chRD = 2'b00; chWR = 2'b10; #1;
    chk("s1_nonown_wr", 32'(dmaWR), 32'd0);
    chWR = 2'b00;
    tick(1);
    chREQ = 2'b00;
    tick(1);
    chk("s1_rel_gnt", 32'(chGNT), 32'd0);
    chk("s1_rel_req", 32'(dmaREQ), 32'd0);
    dmaGNT = 1'b0;
    tick(6);

    // Simultaneous requests from reset; exact gap length; fairness.
    reset = 1'b1; tick(1); reset = 1'b0;
    chREQ = 2'b11;
    tick(1);
    chk("s2_owner0", 32'(owner), 32'd0);
    dmaGNT = 1'b1;
    tick(1);
    chk("s2_gnt0", 32'(chGNT), 32'd1);
    chREQ = 2'b10;
    tick(1);
    chk("s2_gap_req", 32'(dmaREQ), 32'd0);
    dmaGNT = 1'b0;
    n = 0;
    while (!dmaREQ && n < 20) begin
      n++;
      tick(1);
    end
    chk("s2_gap_len", 32'(n), 32'd4);
    chk("s2_owner1", 32'(owner), 32'd1);
    dmaGNT = 1'b1;
    tick(1);
    chk("s2_gnt1", 32'(chGNT), 32'd2);
    chDOUT = {12'o1234, 12'o0000}; chWR = 2'b10; #1;
    chk("s2_dout", 32'(dmaDOUT), 32'o1234);
    chk("s2_wr", 32'(dmaWR), 32'd1);
    chWR = 2'b01; #1;
    chk("s2_nonown_wr", 32'(dmaWR), 32'd0);
    chWR = 2'b00;
    chREQ = 2'b01;
    tick(1);
    dmaGNT = 1'b0; chREQ = 2'b11;
    tick(4);
    chk("s2_next_req", 32'(dmaREQ), 32'd1);
    chk("s2_next_owner", 32'(owner), 32'd0);

    // Watchdog revoke on ch1, masking, and recovery via errCLR.
    dmaGNT = 1'b1; tick(1);
    chREQ = 2'b10; tick(1);
    dmaGNT = 1'b0;
    tick(4);
    chk("s3_owner1", 32'(owner), 32'd1);
    dmaGNT = 1'b1;
    tick(1);
    n = 0;
    while (chGNT != 2'b00 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("s3_wd_len", 32'(n), 32'd1024);
    chk("s3_err", 32'(errFLAG), 32'd2);
    dmaGNT = 1'b0;
    tick(20);
    chk("s3_masked_req", 32'(dmaREQ), 32'd0);
    chk("s3_masked_gnt", 32'(chGNT), 32'd0);
    errCLR = 2'b10; tick(1); errCLR = 2'b00;
    chk("s3_err_clr", 32'(errFLAG), 32'd0);
    tick(1);
    chk("s3_rereq", 32'(dmaREQ), 32'd1);
    dmaGNT = 1'b1;
    tick(1);
    chk("s3_regnt", 32'(chGNT), 32'd2);

    // CPU revokes mid-ownership, then regrants the same channel.
    dmaGNT = 1'b0;
    tick(1);
    chk("s5_revoke_gnt", 32'(chGNT), 32'd0);
    chk("s5_revoke_req", 32'(dmaREQ), 32'd1);
    chk("s5_revoke_owner", 32'(owner), 32'd1);
    dmaGNT = 1'b1;
    tick(1);
    chk("s5_resume", 32'(chGNT), 32'd2);

    // Reset while owning.
    chADDR = {15'o17777, 15'o00200}; #1;
    chk("s6_addr1", 32'(dmaADDR), 32'o17777);
    reset = 1'b1;
    tick(1);
    chk("s6_rst_gnt", 32'(chGNT), 32'd0);
    chk("s6_rst_req", 32'(dmaREQ), 32'd0);
    chk("s6_rst_addr", 32'(dmaADDR), 32'd0);
    reset = 1'b0; chREQ = 2'b00; dmaGNT = 1'b0;
    tick(2);

    // Clear while owning keeps the error flags.
    chREQ = 2'b01; tick(1);
    dmaGNT = 1'b1; tick(1);
    n = 0;
    while (chGNT != 2'b00 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("s6_err0", 32'(errFLAG), 32'd1);
    dmaGNT = 1'b0; chREQ = 2'b11;
    tick(4);
    chk("s6_owner1", 32'(owner), 32'd1);
    dmaGNT = 1'b1;
    tick(1);
    chk("s6_gnt1", 32'(chGNT), 32'd2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("s6_clr_gnt", 32'(chGNT), 32'd0);
    chk("s6_clr_req", 32'(dmaREQ), 32'd0);
    chk("s6_clr_owner", 32'(owner), 32'd0);
    chk("s6_clr_err", 32'(errFLAG), 32'd1);
    chREQ = 2'b00; dmaGNT = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
